pipelined_adder: RTL and testbench

Parametrised, pipelined integer adder/subtractor for the CPU datapath. It splits a WIDTH-bit add or subtract into STAGES equal chunks and carries between chunks through pipeline registers, so wide operands close timing at high clock rates. It accepts one operation per cycle under a valid/ready handshake with backpressure and flush. It reports sum, carry-out, signed overflow and zero. The EX stage and address-generation paths use it where a single-cycle `a + b` adder is too slow.

---
 rtl/pipelined_adder.sv | 162 ++++++++++++++++
 tb/tb_pipelined_adder.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// ---------------------------------------------------------------------------
// pipelined_adder
//
// Pipelined integer adder/subtractor. A WIDTH-bit operation is split into
// STAGES equal chunks of C = WIDTH/STAGES bits. Stage k adds chunk k and
// passes its carry to stage k+1 through a pipeline register. Operands ride
// along with the partial result, so every stage holds a complete operation.
// One operation per cycle is accepted under a valid/ready handshake. The
// pipe supports backpressure (the whole pipe freezes) and a synchronous
// flush that drops everything in flight.
//
// Parameters:
//   WIDTH      operand/result width; must be a multiple of STAGES
//   STAGES     pipeline depth and chunk count (1..WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous; clears every valid bit at the next edge
//   in_valid   operands/mode presented
//   in_ready   block can accept this cycle
//   a, b       operands
//   sub        0: a+b, 1: a-b (computed as a + ~b + 1)
//   out_valid  result available
//   out_ready  consumer takes result this cycle
//   sum        result modulo 2^WIDTH
//   carry_out  carry out of the MSB (for sub: 1 = no borrow)
//   overflow   two's-complement signed overflow
//   zero       sum == 0
// ---------------------------------------------------------------------------
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int C    = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers: operand A, effective B, partial sum, chunk carry, valid.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             v_q [STAGES];
    logic             v_d [STAGES];

    // The flags need the full result, so they are computed alongside the
    // last chunk and registered with it.
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;

    // Inputs seen by each stage: the block inputs for stage 0, the previous
    // stage's register for the rest.
    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];
    logic [C:0]       chunk_sum [STAGES];

    logic             advance;

    // The pipe moves only as a whole; a held result freezes every stage.
    assign advance  = !(v_q[LAST] && !out_ready);
    assign in_ready = advance;

    always_comb begin
        src_a[0] = a;
        src_b[0] = sub ? ~b : b;
        src_s[0] = '0;
        src_c[0] = sub;
        src_v[0] = in_valid && advance;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            chunk_sum[k] = {1'b0, src_a[k][k*C +: C]}
                         + {1'b0, src_b[k][k*C +: C]}
                         + {{C{1'b0}}, src_c[k]};
            a_d[k] = src_a[k];
            b_d[k] = src_b[k];
            s_d[k] = src_s[k];
            s_d[k][k*C +: C] = chunk_sum[k][C-1:0];
            c_d[k] = chunk_sum[k][C];
            v_d[k] = src_v[k];
        end

        // Effective B is used, so subtraction overflow falls out naturally.
        ovf_d  = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
              && (s_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        zero_d = (s_d[LAST] == '0);
    end

    // Data registers load on every advance. Valid bits are cleared by flush
    // regardless of stall; data left behind by a flush is never marked valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            if (advance) begin
                for (int k = 0; k < STAGES; k++) begin
                    a_q[k] <= a_d[k];
                    b_q[k] <= b_d[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
            if (flush) begin
                for (int k = 0; k < STAGES; k++) begin
                    v_q[k] <= 1'b0;
                end
            end else if (advance) begin
                for (int k = 0; k < STAGES; k++) begin
                    v_q[k] <= v_d[k];
                end
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder
//
// Testbench for pipelined_adder. The main DUT is WIDTH=32, STAGES=4. Two
// more instances (STAGES=2 and STAGES=1) share its inputs and are used for
// the asynchronous reset checks. Results of the main DUT are tracked by a
// scoreboard queue of expected results, each tagged with its issue cycle.
// ---------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int STAGES4 = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
        logic        z;
        int          issue;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_ready;

    logic        in_ready4, out_valid4, cout4, ovf4, zero4;
    logic [31:0] sum4;
    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [31:0] sum2;
    logic        in_ready1, out_valid1, cout1, ovf1, zero1;
    logic [31:0] sum1;

    int          tests_run;
    int          tests_failed;
    int          cyc;
    logic        check_lat;
    exp_t        sb [$];
    vec_t        vecs [9];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready4), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4),
        .carry_out(cout4), .overflow(ovf4), .zero(zero4)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready2), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2),
        .carry_out(cout2), .overflow(ovf2), .zero(zero2)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready1), .a(a), .b(b), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1),
        .carry_out(cout1), .overflow(ovf1), .zero(zero1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference arithmetic: full-width add of A and effective B.
    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi,
                                   input logic si);
        exp_t        e;
        logic [31:0] eb;
        logic [32:0] full;
        eb     = si ? ~bi : bi;
        full   = {1'b0, ai} + {1'b0, eb} + {32'd0, si};
        e.sum  = full[31:0];
        e.c    = full[32];
        e.o    = (ai[31] == eb[31]) && (full[31] != ai[31]);
        e.z    = (full[31:0] == 32'd0);
        e.issue = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One cycle, entered and left at a falling edge. Drives the inputs,
    // scores the result consumed at the coming edge, and records an accepted
    // operation on the scoreboard.
    task automatic applyStimulus(input logic v, input logic [31:0] ai,
                                 input logic [31:0] bi, input logic si,
                                 input logic ordy, input logic fl,
                                 input exp_t ex);
        exp_t e;
        in_valid  = v;
        a         = ai;
        b         = bi;
        sub       = si;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (out_valid4 && out_ready) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_out: got sum 0x%08h, expected no result", sum4);
            end else begin
                e = sb.pop_front();
                checkOutput("sum", sum4, e.sum);
                checkBit("carry_out", cout4, e.c);
                checkBit("overflow", ovf4, e.o);
                checkBit("zero", zero4, e.z);
                if (check_lat) begin
                    checkOutput("latency", cyc - e.issue, STAGES4);
                end
            end
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready4) begin
            e       = ex;
            e.issue = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idleCycle(input logic ordy);
        exp_t e;
        e = model(32'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, ordy, 1'b0, e);
    endtask

    task automatic issueOp(input logic [31:0] ai, input logic [31:0] bi,
                           input logic si, input logic ordy);
        applyStimulus(1'b1, ai, bi, si, ordy, 1'b0, model(ai, bi, si));
    endtask

    task automatic drain();
        for (int i = 0; i < 10; i++) begin
            idleCycle(1'b1);
        end
        checkOutput("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkBit({tag, "_out_valid4"}, out_valid4, 1'b0);
        checkOutput({tag, "_sum4"}, sum4, 32'd0);
        checkBit({tag, "_carry4"}, cout4, 1'b0);
        checkBit({tag, "_ovf4"}, ovf4, 1'b0);
        checkBit({tag, "_zero4"}, zero4, 1'b0);
        checkBit({tag, "_in_ready4"}, in_ready4, 1'b1);
        checkBit({tag, "_out_valid2"}, out_valid2, 1'b0);
        checkOutput({tag, "_sum2"}, sum2, 32'd0);
        checkBit({tag, "_flags2"}, cout2 | ovf2 | zero2, 1'b0);
        checkBit({tag, "_in_ready2"}, in_ready2, 1'b1);
        checkBit({tag, "_out_valid1"}, out_valid1, 1'b0);
        checkOutput({tag, "_sum1"}, sum1, 32'd0);
        checkBit({tag, "_flags1"}, cout1 | ovf1 | zero1, 1'b0);
        checkBit({tag, "_in_ready1"}, in_ready1, 1'b1);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        // Hand-computed vectors: {a, b, sub, sum, carry, overflow, zero}.
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};

        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        check_lat    = 1'b1;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        sub          = 1'b0;
        out_ready    = 1'b1;

        #2;
        checkResetState("reset");
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, one at a time, latency checked by the scoreboard.
        for (int i = 0; i < 9; i++) begin
            checkBit("idle_in_ready", in_ready4, 1'b1);
            e.sum = vecs[i].sum;
            e.c   = vecs[i].c;
            e.o   = vecs[i].o;
            e.z   = vecs[i].z;
            e.issue = 0;
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, 1'b0, e);
            for (int j = 0; j < 5; j++) begin
                idleCycle(1'b1);
            end
        end
        checkOutput("vectors_done", sb.size(), 32'd0);

        // Back-to-back stream of random operations.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom();
            rb = $urandom();
            rs = ($urandom_range(1, 0) != 0);
            issueOp(ra, rb, rs, 1'b1);
            checkBit("stream_in_ready", in_ready4, 1'b1);
        end
        drain();

        // Backpressure: fill the pipe, then hold out_ready low for 3 cycles.
        for (int i = 0; i < 4; i++) begin
            issueOp(32'h01000000 * (i + 1), 32'h00FF00FF, 1'b0, 1'b1);
        end
        check_lat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issueOp(32'hDEADBEEF, 32'h11111111, 1'b1, 1'b0);
            checkBit("stall_out_valid", out_valid4, 1'b1);
            checkBit("stall_in_ready", in_ready4, 1'b0);
            checkOutput("stall_sum", sum4, sb[0].sum);
            checkBit("stall_carry", cout4, sb[0].c);
        end
        issueOp(32'hDEADBEEF, 32'h11111111, 1'b1, 1'b1);
        drain();
        check_lat = 1'b1;

        // Flush with 3 operations in flight and a fourth presented.
        for (int i = 0; i < 3; i++) begin
            issueOp(32'h00000100 + i, 32'h00000010, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 32'h55555555, 32'h22222222, 1'b0, 1'b1, 1'b1,
                      model(32'h55555555, 32'h22222222, 1'b0));
        checkBit("flush_out_valid", out_valid4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idleCycle(1'b1);
            checkBit("flush_quiet", out_valid4, 1'b0);
        end
        issueOp(32'h00000009, 32'h00000004, 1'b1, 1'b1);
        drain();

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            issueOp(32'h00001000 + i, 32'h00000003, 1'b0, 1'b1);
        end
        checkBit("pre_reset_valid4", out_valid4, 1'b1);
        checkBit("pre_reset_valid2", out_valid2, 1'b1);
        checkBit("pre_reset_valid1", out_valid1, 1'b1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkResetState("async_reset");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            idleCycle(1'b1);
            checkBit("post_reset_valid4", out_valid4, 1'b0);
            checkBit("post_reset_valid2", out_valid2, 1'b0);
            checkBit("post_reset_valid1", out_valid1, 1'b0);
        end
        issueOp(32'hFFFFFFF0, 32'h00000020, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
